// File: rtl/seg7_pattern_decoder.sv
// Debounces an active-low 7-segment bus and decodes it back to a hex nibble
// behind a one-entry valid/ready register. Define SEG7_ERRCNT_EN to add ERR_COUNT.
module seg7_pattern_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [6:0] SEG,
    input  logic       OUT_READY,
    input  logic       CLR_OVF,
    output logic [3:0] NIBBLE,
    output logic       OUT_VALID,
    output logic       BLANK,
    output logic       ERR,
`ifdef SEG7_ERRCNT_EN
    output logic       OVF,
    output logic [7:0] ERR_COUNT
`else
    output logic       OVF
`endif
);

    localparam logic [CNT_W-1:0] CntMax    = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CntAccept = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [6:0]       SegBlank  = 7'h7F;

    typedef enum logic {StTrack, StSettled} state_e;

    state_e           state_q;
    logic [6:0]       seg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       nibble_q;
    logic             valid_q;
    logic             blank_q;
    logic             err_q;
    logic             ovf_q;

    logic             same;
    logic             accept;
    logic             legal;
    logic [3:0]       dec;
    logic             consume;
    logic             ovf_set;
    logic             err_set;

    always_comb begin
        legal = 1'b1;
        dec   = 4'h0;
        unique case (seg_q)
            7'h40: dec = 4'h0;
            7'h79: dec = 4'h1;
            7'h24: dec = 4'h2;
            7'h30: dec = 4'h3;
            7'h19: dec = 4'h4;
            7'h12: dec = 4'h5;
            7'h02: dec = 4'h6;
            7'h78: dec = 4'h7;
            7'h00: dec = 4'h8;
            7'h10: dec = 4'h9;
            7'h08: dec = 4'hA;
            7'h03: dec = 4'hB;
            7'h46: dec = 4'hC;
            7'h21: dec = 4'hD;
            7'h06: dec = 4'hE;
            7'h0E: dec = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        same    = (SEG == seg_q);
        accept  = (state_q == StTrack) && same && (cnt_q == CntAccept);
        consume = valid_q && OUT_READY;
        // A full, unconsumed holding register drops the new value.
        ovf_set = accept && legal && valid_q && !OUT_READY;
        err_set = accept && !legal && (seg_q != SegBlank);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= StTrack;
            seg_q    <= SegBlank;
            cnt_q    <= '0;
            nibble_q <= 4'h0;
            valid_q  <= 1'b0;
            blank_q  <= 1'b1;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            seg_q <= SEG;
            if (!same) begin
                cnt_q <= '0;
            end else if (cnt_q != CntMax) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            unique case (state_q)
                StTrack:   if (accept) state_q <= StSettled;
                StSettled: if (!same) state_q <= StTrack;
                default:   state_q <= StTrack;
            endcase

            if (consume) valid_q <= 1'b0;
            if (accept) begin
                if (legal) begin
                    blank_q <= 1'b0;
                    if (!ovf_set) begin
                        nibble_q <= dec;
                        valid_q  <= 1'b1;
                    end
                end else if (seg_q == SegBlank) begin
                    blank_q <= 1'b1;
                end
            end

            err_q <= err_set;
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (CLR_OVF) begin
                ovf_q <= 1'b0;
            end
        end
    end

`ifdef SEG7_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            err_cnt_q <= 8'h00;
        end else if (err_set) begin
            if (CLR_OVF) begin
                err_cnt_q <= 8'h01;
            end else if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'h01;
            end
        end else if (CLR_OVF) begin
            err_cnt_q <= 8'h00;
        end
    end

    assign ERR_COUNT = err_cnt_q;
`endif

    assign NIBBLE    = nibble_q;
    assign OUT_VALID = valid_q;
    assign BLANK     = blank_q;
    assign ERR       = err_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Directed bench for seg7_pattern_decoder: per-cycle vector table plus
// hand-written sequences for the glyph walk, consume+accept and mid-filter reset.
module tb_seg7_pattern_decoder;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg;
    logic       out_ready;
    logic       clr_ovf;
    logic [3:0] nibble;
    logic       out_valid;
    logic       blank;
    logic       err;
    logic       ovf;
`ifdef SEG7_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int checks = 0;
    int errors = 0;

    seg7_pattern_decoder #(
        .STABLE_CYCLES(4),
        .CNT_W        (8)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .SEG      (seg),
        .OUT_READY(out_ready),
        .CLR_OVF  (clr_ovf),
        .NIBBLE   (nibble),
        .OUT_VALID(out_valid),
        .BLANK    (blank),
        .ERR      (err),
`ifdef SEG7_ERRCNT_EN
        .OVF      (ovf),
        .ERR_COUNT(err_count)
`else
        .OVF      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic       rdy;
        logic       clr;
        logic [3:0] nib;
        logic       vld;
        logic       blk;
        logic       err;
        logic       ovf;
        logic [7:0] ecnt;
    } vec_t;

    vec_t vecs[$];
    logic [6:0] glyph_tab [16];

    task automatic add(input int n, input logic [6:0] s, input logic r, input logic c,
                       input logic [3:0] nb, input logic v, input logic b, input logic e,
                       input logic o, input logic [7:0] ec);
        vec_t t;
        t.seg = s; t.rdy = r; t.clr = c; t.nib = nb; t.vld = v;
        t.blk = b; t.err = e; t.ovf = o; t.ecnt = ec;
        for (int k = 0; k < n; k++) vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] nb, input logic v,
                            input logic b, input logic e, input logic o);
        chk({tag, " NIBBLE"},    {4'h0, nibble}, {4'h0, nb});
        chk({tag, " OUT_VALID"}, {7'h0, out_valid}, {7'h0, v});
        chk({tag, " BLANK"},     {7'h0, blank}, {7'h0, b});
        chk({tag, " ERR"},       {7'h0, err}, {7'h0, e});
        chk({tag, " OVF"},       {7'h0, ovf}, {7'h0, o});
    endtask

    task automatic step(input logic [6:0] s, input logic r, input logic c);
        seg = s; out_ready = r; clr_ovf = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_nib;
        glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        // seg, rdy, clr | nib, vld, blk, err, ovf, ecnt  (outputs after the edge)
        add(1, 7'h7F, 0, 0, 4'h3 & 4'h0, 0, 1, 0, 0, 0);
        add(4, 7'h30, 0, 0, 4'h0, 0, 1, 0, 0, 0);
        add(4, 7'h30, 0, 0, 4'h3, 1, 0, 0, 0, 0);
        add(2, 7'h30, 1, 0, 4'h3, 0, 0, 0, 0, 0);
        add(4, 7'h24, 1, 0, 4'h3, 0, 0, 0, 0, 0);
        add(1, 7'h24, 1, 0, 4'h2, 1, 0, 0, 0, 0);
        add(2, 7'h24, 1, 0, 4'h2, 0, 0, 0, 0, 0);
        add(2, 7'h00, 1, 0, 4'h2, 0, 0, 0, 0, 0);
        add(4, 7'h24, 1, 0, 4'h2, 0, 0, 0, 0, 0);
        add(1, 7'h24, 1, 0, 4'h2, 1, 0, 0, 0, 0);
        add(1, 7'h24, 1, 0, 4'h2, 0, 0, 0, 0, 0);
        add(4, 7'h7F, 1, 0, 4'h2, 0, 0, 0, 0, 0);
        add(1, 7'h7F, 1, 0, 4'h2, 0, 1, 0, 0, 0);
        add(4, 7'h55, 1, 0, 4'h2, 0, 1, 0, 0, 0);
        add(1, 7'h55, 1, 0, 4'h2, 0, 1, 1, 0, 1);
        add(1, 7'h55, 1, 0, 4'h2, 0, 1, 0, 0, 1);
        add(4, 7'h40, 0, 0, 4'h2, 0, 1, 0, 0, 1);
        add(1, 7'h40, 0, 0, 4'h0, 1, 0, 0, 0, 1);
        add(4, 7'h79, 0, 0, 4'h0, 1, 0, 0, 0, 1);
        add(1, 7'h79, 0, 0, 4'h0, 1, 0, 0, 1, 1);
        add(1, 7'h79, 0, 1, 4'h0, 1, 0, 0, 0, 0);
        add(1, 7'h79, 1, 0, 4'h0, 0, 0, 0, 0, 0);

        rst_n = 1'b0; seg = 7'h7F; out_ready = 1'b0; clr_ovf = 1'b0;
        #12;
        chk_outs("reset", 4'h0, 0, 1, 0, 0);
`ifdef SEG7_ERRCNT_EN
        chk("reset ERR_COUNT", err_count, 8'h00);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].seg, vecs[i].rdy, vecs[i].clr);
            chk_outs($sformatf("vec%0d", i + 1), vecs[i].nib, vecs[i].vld, vecs[i].blk,
                     vecs[i].err, vecs[i].ovf);
`ifdef SEG7_ERRCNT_EN
            chk($sformatf("vec%0d ERR_COUNT", i + 1), err_count, vecs[i].ecnt);
`endif
        end

        // Walk all glyphs, six cycles each, consumer always ready.
        exp_nib = 4'h0;
        for (int g = 0; g < 16; g++) begin
            for (int c = 0; c < 6; c++) begin
                step(glyph_tab[g], 1'b1, 1'b0);
                if (c == 4) exp_nib = 4'(g);
                chk_outs($sformatf("walk g%0d c%0d", g, c), exp_nib, (c == 4), 0, 0, 0);
            end
        end

        // Consume and a new legal accept on the same edge.
        for (int c = 0; c < 5; c++) begin
            step(7'h40, 1'b0, 1'b0);
            chk_outs($sformatf("sim a%0d", c), (c == 4) ? 4'h0 : 4'hF, (c == 4), 0, 0, 0);
        end
        for (int c = 0; c < 4; c++) begin
            step(7'h79, 1'b0, 1'b0);
            chk_outs($sformatf("sim b%0d", c), 4'h0, 1, 0, 0, 0);
        end
        step(7'h79, 1'b1, 1'b0);
        chk_outs("sim load", 4'h1, 1, 0, 0, 0);
        step(7'h79, 1'b1, 1'b0);
        chk_outs("sim drain", 4'h1, 0, 0, 0, 0);

        // Reset in the middle of filtering the next glyph.
        for (int c = 0; c < 6; c++) begin
            step(7'h12, 1'b1, 1'b0);
            chk_outs($sformatf("rst settle c%0d", c), (c >= 4) ? 4'h5 : 4'h1, (c == 4),
                     0, 0, 0);
        end
        step(7'h02, 1'b1, 1'b0);
        step(7'h02, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_outs("mid reset", 4'h0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(7'h02, 1'b0, 1'b0);
            chk_outs($sformatf("post rst r%0d", c + 1), (c == 4) ? 4'h6 : 4'h0, (c == 4),
                     (c != 4), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
